cpu_bus_ctrl: RTL and testbench
===============================

Name: cpu_bus_ctrl

Overview:
Bus controller directly downstream of the cpu block. It consumes the CPU's external bus transactions (strobe, write enable, address, write data), decodes the address into peripheral regions, and runs a per-device request/acknowledge handshake with a timeout. It returns read data and a one-cycle completion pulse that feeds the CPU's data-ready input.

Parameters:
ADDR_W, 32, CPU bus address width
DATA_W, 32, CPU bus data width
DEV0_PAGE, 16'h0001, value of addr[31:16] that selects device 0
DEV1_PAGE, 16'h0002, value of addr[31:16] that selects device 1
TIMEOUT, 16, cycles sel may stay high without ack (>=2)
ERR_DATA, 32'hFFFF_FFFF, read data returned on unmapped or timed-out access

Ports:
i_cpu_clk  in  1  sole clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_bus_clk  in  1  CPU bus strobe; a 0->1 transition starts a transaction
i_bus_we  in  1  1 = write, 0 = read; sampled at the strobe edge
i_bus_addr  in  ADDR_W  transaction address; sampled at the strobe edge
i_bus_data  in  DATA_W  write data from CPU; sampled at the strobe edge
o_bus_data  out  DATA_W  read data to CPU
o_bus_data_ready  out  1  one-cycle completion pulse to CPU
o_bus_err  out  1  one-cycle error pulse, coincident with ready
o_busy  out  1  high whenever state != IDLE
o_dev_sel  out  2  one-hot device select
o_dev_we  out  1  device write enable
o_dev_addr  out  16  device offset (addr[15:0])
o_dev_wdata  out  DATA_W  device write data
i_dev_rdata  in  DATA_W  shared device read data; valid with ack
i_dev_ack  in  2  per-device acknowledge

Behaviour:
- Reset: state IDLE. All outputs are 0, including o_bus_data. The strobe history register is 0 and the timeout counter is 0.
- Edge detect: a registered copy of i_bus_clk is kept. start = i_bus_clk & ~prev.
  - prev updates every cycle in every state.
  - A start seen outside IDLE is ignored, with no side effects.
- States: IDLE, ACCESS, RESPOND.
- IDLE, start in cycle N:
  - we, addr and data are latched in cycle N.
  - Mapped address: next state ACCESS. From cycle N+1, o_dev_sel = one-hot of the decoded device, o_dev_we = latched we, o_dev_addr = latched addr[15:0]. o_dev_wdata = latched data on writes and 0 on reads. The timeout counter clears to 0.
  - Unmapped address (addr[31:16] matches neither page, including the 0x0000 page): next state RESPOND directly. o_dev_sel stays 0.
- ACCESS:
  - Device outputs are held stable. Only i_dev_ack bit k, where o_dev_sel[k]=1, is honoured; ack on the other bit is ignored.
  - Ack in cycle M: capture i_dev_rdata for reads. For writes, the captured value is 0. Go to RESPOND. o_dev_sel and o_dev_we are 0 from M+1.
  - No ack: the counter increments. If the counter equals TIMEOUT-1 in a no-ack cycle, take the timeout path: capture ERR_DATA, set the error flag, go to RESPOND. Sel is therefore high for exactly TIMEOUT cycles.
  - Ack in the same cycle as the timeout condition: ack wins, no error.
- RESPOND (one cycle):
  - o_bus_data_ready = 1.
  - o_bus_data = captured value. It is updated at RESPOND entry and held until the next RESPOND.
  - o_bus_err = 1 for unmapped or timeout, else 0.
  - Next state IDLE.
  - A start arriving in the RESPOND cycle is ignored. A start arriving on the cycle after RESPOND is accepted.
- Latency:
  - Mapped access: ready at cycle M+1, where M is the ack cycle. Minimum is N+2, with ack at N+1.
  - Unmapped access: ready at N+1.
  - Timeout: ready at N+TIMEOUT+1.
- o_busy = (state != IDLE). It is combinational from the state register.
- Reset mid-operation: state is IDLE the next cycle and all device outputs are 0. No ready or err pulse is issued for the aborted transaction. o_bus_data is cleared to 0.
- Width rules:
  - o_dev_addr is truncated to addr[15:0].
  - The counter is wide enough to hold TIMEOUT-1 and never wraps.
- Level-held strobe: a strobe held high across many cycles produces exactly one transaction.

Test Plan:
- Read dev0: addr 0x0001_0040, ack at N+3 with rdata 0x1234_5678 -> sel=2'b01 for N+1..N+3, o_dev_addr=0x0040; ready pulse at N+4 with o_bus_data=0x1234_5678 and err=0.
- Write dev1: addr 0x0002_0008, data 0xCAFE_F00D, ack at N+1 -> o_dev_we=1 and o_dev_wdata=0xCAFE_F00D at N+1; ready at N+2; sel=0 at N+2.
- Unmapped read at 0x0005_0000 -> no sel; ready and err both high at N+1; o_bus_data=0xFFFF_FFFF.
- Timeout with TIMEOUT=8: dev0 read with no ack -> sel high N+1..N+8; ready and err at N+9; data=ERR_DATA. Variant with ack at N+8 -> err=0.
- Wrong-device ack and ignored edges: ack[1] while sel=01 is ignored. A strobe re-toggled during ACCESS starts no second transaction. A strobe held high for 20 cycles yields exactly one ready pulse.
- Reset in ACCESS: i_rst at N+2 -> sel=0 and busy=0 at N+3; no ready pulse; a new strobe afterwards completes normally.

Source files
------------

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus and device-side handshake signals of the bus controller.
// The controller takes the slave view; the CPU/device side takes the master view.
interface cpu_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_bus_clk;
    logic              i_bus_we;
    logic [ADDR_W-1:0] i_bus_addr;
    logic [DATA_W-1:0] i_bus_data;
    logic [DATA_W-1:0] o_bus_data;
    logic              o_bus_data_ready;
    logic              o_bus_err;
    logic              o_busy;
    logic [1:0]        o_dev_sel;
    logic              o_dev_we;
    logic [15:0]       o_dev_addr;
    logic [DATA_W-1:0] o_dev_wdata;
    logic [DATA_W-1:0] i_dev_rdata;
    logic [1:0]        i_dev_ack;

    modport slave (
        input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        input  i_dev_rdata, i_dev_ack,
        output o_bus_data, o_bus_data_ready, o_bus_err, o_busy,
        output o_dev_sel, o_dev_we, o_dev_addr, o_dev_wdata
    );

    modport master (
        output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        output i_dev_rdata, i_dev_ack,
        input  o_bus_data, o_bus_data_ready, o_bus_err, o_busy,
        input  o_dev_sel, o_dev_we, o_dev_addr, o_dev_wdata
    );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// Bus controller behind the CPU: decodes pages into two devices,
// runs a req/ack handshake with timeout, returns data plus a ready pulse.
module cpu_bus_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [15:0] DEV0_PAGE = 16'h0001,
    parameter logic [15:0] DEV1_PAGE = 16'h0002,
    parameter int          TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input logic i_cpu_clk,
    input logic i_rst,
    cpu_bus_ctrl_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic [1:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic        start;
    logic        ack_hit;
    logic [15:0] page;

    assign start   = bus.i_bus_clk & ~prev_q;
    assign ack_hit = |(bus.i_dev_ack & sel_q);
    assign page    = bus.i_bus_addr[ADDR_W-1 -: 16];

    // Next-state and datapath: decode on strobe edge, wait for ack or timeout.
    always_comb begin
        state_d = state_q;
        prev_d  = bus.i_bus_clk;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (page == DEV0_PAGE || page == DEV1_PAGE) begin
                        sel_d   = (page == DEV0_PAGE) ? 2'b01 : 2'b10;
                        we_d    = bus.i_bus_we;
                        addr_d  = bus.i_bus_addr[15:0];
                        wdata_d = bus.i_bus_we ? bus.i_bus_data : '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        data_d  = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    data_d  = we_q ? '0 : bus.i_dev_rdata;
                    err_d   = 1'b0;
                    sel_d   = 2'b00;
                    we_d    = 1'b0;
                    state_d = RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    sel_d   = 2'b00;
                    we_d    = 1'b0;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESPOND: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_bus_data       = data_q;
    assign bus.o_bus_data_ready = (state_q == RESPOND);
    assign bus.o_bus_err        = (state_q == RESPOND) & err_q;
    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_dev_sel        = sel_q;
    assign bus.o_dev_we         = we_q;
    assign bus.o_dev_addr       = addr_q;
    assign bus.o_dev_wdata      = wdata_q;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl with TIMEOUT=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cpu_bus_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   nsel;
    int   nrdy;

    cpu_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_bus_ctrl #(
        .ADDR_W(32), .DATA_W(32),
        .DEV0_PAGE(16'h0001), .DEV1_PAGE(16'h0002),
        .TIMEOUT(8), .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .i_cpu_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic we, input logic [31:0] a,
                          input logic [31:0] d);
        bus.i_bus_clk  = 1'b1;
        bus.i_bus_we   = we;
        bus.i_bus_addr = a;
        bus.i_bus_data = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_bus_clk   = 1'b0;
        bus.i_bus_we    = 1'b0;
        bus.i_bus_addr  = '0;
        bus.i_bus_data  = '0;
        bus.i_dev_rdata = '0;
        bus.i_dev_ack   = 2'b00;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_rdy", 32'(bus.o_bus_data_ready), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_sel", 32'(bus.o_dev_sel), 0);
        chk("rst_data", bus.o_bus_data, 0);
        chk("rst_err", 32'(bus.o_bus_err), 0);

        // read dev0, ack at N+3
        strobe(1'b0, 32'h0001_0040, 32'h0);
        step();
        bus.i_bus_clk = 1'b0;
        chk("rd_sel1", 32'(bus.o_dev_sel), 32'h1);
        chk("rd_addr", 32'(bus.o_dev_addr), 32'h0040);
        chk("rd_wdata", bus.o_dev_wdata, 0);
        chk("rd_busy", 32'(bus.o_busy), 1);
        chk("rd_rdy1", 32'(bus.o_bus_data_ready), 0);
        step();
        chk("rd_sel2", 32'(bus.o_dev_sel), 32'h1);
        step();
        bus.i_dev_ack   = 2'b01;
        bus.i_dev_rdata = 32'h1234_5678;
        chk("rd_sel3", 32'(bus.o_dev_sel), 32'h1);
        step();
        bus.i_dev_ack = 2'b00;
        chk("rd_rdy", 32'(bus.o_bus_data_ready), 1);
        chk("rd_data", bus.o_bus_data, 32'h1234_5678);
        chk("rd_err", 32'(bus.o_bus_err), 0);
        chk("rd_sel4", 32'(bus.o_dev_sel), 0);
        step();
        chk("rd_rdy_off", 32'(bus.o_bus_data_ready), 0);
        chk("rd_idle", 32'(bus.o_busy), 0);
        chk("rd_hold", bus.o_bus_data, 32'h1234_5678);

        // write dev1, ack at N+1
        strobe(1'b1, 32'h0002_0008, 32'hCAFE_F00D);
        step();
        bus.i_bus_clk = 1'b0;
        chk("wr_sel", 32'(bus.o_dev_sel), 32'h2);
        chk("wr_we", 32'(bus.o_dev_we), 1);
        chk("wr_wdata", bus.o_dev_wdata, 32'hCAFE_F00D);
        chk("wr_addr", 32'(bus.o_dev_addr), 32'h0008);
        bus.i_dev_ack = 2'b10;
        step();
        bus.i_dev_ack = 2'b00;
        chk("wr_rdy", 32'(bus.o_bus_data_ready), 1);
        chk("wr_sel0", 32'(bus.o_dev_sel), 0);
        chk("wr_we0", 32'(bus.o_dev_we), 0);
        chk("wr_data", bus.o_bus_data, 0);
        chk("wr_err", 32'(bus.o_bus_err), 0);
        step();

        // unmapped pages 0x0005 and 0x0000
        strobe(1'b0, 32'h0005_0000, 32'h0);
        step();
        bus.i_bus_clk = 1'b0;
        chk("um_sel", 32'(bus.o_dev_sel), 0);
        chk("um_rdy", 32'(bus.o_bus_data_ready), 1);
        chk("um_err", 32'(bus.o_bus_err), 1);
        chk("um_data", bus.o_bus_data, 32'hFFFF_FFFF);
        step();
        chk("um_rdy_off", 32'(bus.o_bus_data_ready), 0);
        chk("um_err_off", 32'(bus.o_bus_err), 0);
        strobe(1'b0, 32'h0000_1234, 32'h0);
        step();
        bus.i_bus_clk = 1'b0;
        chk("um0_err", 32'(bus.o_bus_err), 1);
        chk("um0_sel", 32'(bus.o_dev_sel), 0);
        step();

        // timeout, no ack
        strobe(1'b0, 32'h0001_0000, 32'h0);
        nsel = 0;
        nrdy = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            bus.i_bus_clk = 1'b0;
            if (bus.o_dev_sel == 2'b01) nsel++;
            if (bus.o_bus_data_ready) nrdy++;
        end
        chk("to_selcnt", 32'(nsel), 8);
        chk("to_early", 32'(nrdy), 0);
        step();
        chk("to_sel0", 32'(bus.o_dev_sel), 0);
        chk("to_rdy", 32'(bus.o_bus_data_ready), 1);
        chk("to_err", 32'(bus.o_bus_err), 1);
        chk("to_data", bus.o_bus_data, 32'hFFFF_FFFF);
        step();

        // ack in the timeout cycle wins
        strobe(1'b0, 32'h0001_0004, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            bus.i_bus_clk = 1'b0;
        end
        step();
        bus.i_dev_ack   = 2'b01;
        bus.i_dev_rdata = 32'hA5A5_A5A5;
        chk("tw_sel", 32'(bus.o_dev_sel), 32'h1);
        step();
        bus.i_dev_ack = 2'b00;
        chk("tw_rdy", 32'(bus.o_bus_data_ready), 1);
        chk("tw_err", 32'(bus.o_bus_err), 0);
        chk("tw_data", bus.o_bus_data, 32'hA5A5_A5A5);
        step();

        // wrong-device ack and strobe re-toggle in ACCESS
        strobe(1'b0, 32'h0001_0010, 32'h0);
        step();
        bus.i_bus_clk = 1'b0;
        bus.i_dev_ack = 2'b10;
        step();
        bus.i_dev_ack = 2'b00;
        bus.i_bus_clk = 1'b1;
        chk("wa_sel", 32'(bus.o_dev_sel), 32'h1);
        chk("wa_rdy", 32'(bus.o_bus_data_ready), 0);
        step();
        bus.i_bus_clk   = 1'b0;
        bus.i_dev_ack   = 2'b01;
        bus.i_dev_rdata = 32'h1111_2222;
        step();
        bus.i_dev_ack = 2'b00;
        chk("wa_rdy2", 32'(bus.o_bus_data_ready), 1);
        chk("wa_data", bus.o_bus_data, 32'h1111_2222);
        nrdy = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.o_bus_data_ready) nrdy++;
        end
        chk("wa_nosecond", 32'(nrdy), 0);

        // strobe held high for 20 cycles
        strobe(1'b0, 32'h0002_0020, 32'h0);
        bus.i_dev_ack   = 2'b10;
        bus.i_dev_rdata = 32'h0BAD_F00D;
        nrdy = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.o_bus_data_ready) nrdy++;
        end
        bus.i_bus_clk = 1'b0;
        bus.i_dev_ack = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.o_bus_data_ready) nrdy++;
        end
        chk("held_cnt", 32'(nrdy), 1);
        chk("held_data", bus.o_bus_data, 32'h0BAD_F00D);

        // reset during ACCESS
        strobe(1'b0, 32'h0001_0000, 32'h0);
        step();
        bus.i_bus_clk = 1'b0;
        step();
        rst = 1'b1;
        chk("ra_busy_pre", 32'(bus.o_busy), 1);
        step();
        rst = 1'b0;
        chk("ra_sel", 32'(bus.o_dev_sel), 0);
        chk("ra_busy", 32'(bus.o_busy), 0);
        chk("ra_rdy", 32'(bus.o_bus_data_ready), 0);
        chk("ra_data", bus.o_bus_data, 0);
        nrdy = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.o_bus_data_ready) nrdy++;
        end
        chk("ra_nopulse", 32'(nrdy), 0);
        strobe(1'b0, 32'h0001_0002, 32'h0);
        step();
        bus.i_bus_clk   = 1'b0;
        bus.i_dev_ack   = 2'b01;
        bus.i_dev_rdata = 32'h5555_AAAA;
        chk("ra_sel2", 32'(bus.o_dev_sel), 32'h1);
        step();
        bus.i_dev_ack = 2'b00;
        chk("ra_rdy2", 32'(bus.o_bus_data_ready), 1);
        chk("ra_data2", bus.o_bus_data, 32'h5555_AAAA);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
